// File: rtl/program_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed little-endian
// byte stream into 32-bit words, writes them out and holds the core in reset until done.
module program_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        restart,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_rst,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_HEADER,
      S_PAYLOAD,
      S_DONE_ENTRY,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [23:0] shift_reg;
   logic [31:0] n_words;
   logic [31:0] word_idx;
   logic [31:0] word_in;
   logic        accept;

   // The first three bytes of a group sit in shift_reg; the fourth completes the word.
   assign word_in  = {in_data, shift_reg};
   assign in_ready = !rst && (state == S_HEADER || state == S_PAYLOAD);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_HEADER;
         byte_cnt  <= 2'd0;
         shift_reg <= '0;
         n_words   <= '0;
         word_idx  <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= BASE_ADDR;
         wr_data   <= '0;
         core_rst  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_HEADER: begin
               if (accept) begin
                  byte_cnt  <= byte_cnt + 2'd1;
                  shift_reg <= {in_data, shift_reg[23:8]};
                  if (byte_cnt == 2'd3) begin
                     n_words  <= word_in;
                     word_idx <= '0;
                     if (word_in > DEPTH_WORDS) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                     end else if (word_in == '0) begin
                        state <= S_DONE_ENTRY;
                     end else begin
                        state <= S_PAYLOAD;
                     end
                  end
               end
            end

            S_PAYLOAD: begin
               if (accept) begin
                  byte_cnt  <= byte_cnt + 2'd1;
                  shift_reg <= {in_data, shift_reg[23:8]};
                  if (byte_cnt == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_data  <= word_in;
                     wr_addr  <= BASE_ADDR + (word_idx << 2);
                     word_idx <= word_idx + 32'd1;
                     if (word_idx == n_words - 32'd1) begin
                        state <= S_DONE_ENTRY;
                     end
                  end
               end
            end

            // The entry substate delays the core release by one cycle so the
            // final write has landed before the first fetch.
            S_DONE_ENTRY, S_DONE, S_ERROR: begin
               if (restart) begin
                  state     <= S_HEADER;
                  byte_cnt  <= 2'd0;
                  shift_reg <= '0;
                  n_words   <= '0;
                  word_idx  <= '0;
                  core_rst  <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
               end else if (state == S_DONE_ENTRY) begin
                  state    <= S_DONE;
                  core_rst <= 1'b0;
                  done     <= 1'b1;
               end
            end

            default: begin
               state <= S_HEADER;
            end
         endcase
      end
   end

endmodule
